// File: rtl/row_col_stream_mux_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | row_col_stream_mux_if : request / streamed-beat bundle for the mux       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface row_col_stream_mux_if #(
   parameter int DATA_WIDTH      = 16,
   parameter int MATRIX_DIM      = 4,
   parameter int LANES           = 2,
   parameter int NUM_SELECT_BITS = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1
);
   localparam int BEATS     = MATRIX_DIM / LANES;
   localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [MATRIX_DIM*MATRIX_DIM*DATA_WIDTH-1:0] matrix_in;
   logic                                        req_valid;
   logic                                        req_ready;
   logic                                        req_mode;
   logic [NUM_SELECT_BITS-1:0]                  req_select;
   logic                                        out_valid;
   logic                                        out_ready;
   logic [LANES*DATA_WIDTH-1:0]                 out_data;
   logic                                        out_last;
   logic [BEAT_BITS-1:0]                        out_beat;
   logic                                        out_err;

   modport master (
      output matrix_in, req_valid, req_mode, req_select, out_ready,
      input  req_ready, out_valid, out_data, out_last, out_beat, out_err
   );

   modport slave (
      input  matrix_in, req_valid, req_mode, req_select, out_ready,
      output req_ready, out_valid, out_data, out_last, out_beat, out_err
   );
endinterface
`default_nettype wire

// File: rtl/row_col_stream_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | row_col_stream_mux : snapshots a matrix row/column, streams it in beats  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module row_col_stream_mux #(
   parameter int DATA_WIDTH      = 16,
   parameter int MATRIX_DIM      = 4,
   parameter int LANES           = 2,
   parameter int NUM_SELECT_BITS = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   row_col_stream_mux_if.slave  bus
);
   localparam int BEATS     = MATRIX_DIM / LANES;
   localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BEAT_W    = LANES * DATA_WIDTH;

   localparam logic [0:0] C_IDLE   = 1'b0;
   localparam logic [0:0] C_STREAM = 1'b1;

   localparam logic [BEAT_BITS-1:0] C_LAST_BEAT = BEAT_BITS'(BEATS - 1);

   if ((LANES < 1) || (LANES > MATRIX_DIM) || ((MATRIX_DIM % LANES) != 0)) begin : g_bad_lanes
      $error("row_col_stream_mux: LANES must divide MATRIX_DIM");
   end

   logic [DATA_WIDTH-1:0] mat_e   [MATRIX_DIM][MATRIX_DIM];
   logic [DATA_WIDTH-1:0] cap_row [MATRIX_DIM];
   logic [DATA_WIDTH-1:0] cap_col [MATRIX_DIM];
   logic [BEAT_W-1:0]     cap_beats [BEATS];
   logic                  sel_oor;

   for (genvar r = 0; r < MATRIX_DIM; r++) begin : g_row
      for (genvar c = 0; c < MATRIX_DIM; c++) begin : g_col
         assign mat_e[r][c] = bus.matrix_in[((r*MATRIX_DIM)+c)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Out-of-range reads of mat_e are masked by sel_oor below.
   assign sel_oor = ({1'b0, bus.req_select} >= (NUM_SELECT_BITS+1)'(MATRIX_DIM));

   for (genvar j = 0; j < MATRIX_DIM; j++) begin : g_cap
      assign cap_row[j] = mat_e[bus.req_select][j];
      assign cap_col[j] = mat_e[j][bus.req_select];
   end

   for (genvar b = 0; b < BEATS; b++) begin : g_beat
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         assign cap_beats[b][k*DATA_WIDTH +: DATA_WIDTH] =
            sel_oor      ? '0 :
            bus.req_mode ? cap_col[(b*LANES)+k] : cap_row[(b*LANES)+k];
      end
   end

   logic [0:0]           state_q, state_d;
   logic [BEAT_BITS-1:0] beat_q,  beat_d;
   logic                 err_q,   err_d;
   logic                 ready_q, ready_d;
   logic [BEAT_W-1:0]    vec_q [BEATS];
   logic [BEAT_W-1:0]    vec_d [BEATS];

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      err_d   = err_q;
      vec_d   = vec_q;
      case (state_q)
         C_IDLE: begin
            if (bus.req_valid && ready_q) begin
               state_d = C_STREAM;
               beat_d  = '0;
               err_d   = sel_oor;
               vec_d   = cap_beats;
            end
         end
         C_STREAM: begin
            if (bus.out_ready) begin
               if (beat_q == C_LAST_BEAT) begin
                  state_d = C_IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + BEAT_BITS'(1);
               end
            end
         end
         default: state_d = C_IDLE;
      endcase
      // Registered so that ready stays low until the first edge after reset.
      ready_d = (state_d == C_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= C_IDLE;
         beat_q  <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
         vec_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         vec_q   <= vec_d;
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.out_valid = (state_q == C_STREAM);
   assign bus.out_data  = vec_q[beat_q];
   assign bus.out_last  = (state_q == C_STREAM) && (beat_q == C_LAST_BEAT);
   assign bus.out_beat  = beat_q;
   assign bus.out_err   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_row_col_stream_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_row_col_stream_mux : randomized bench with a vector-level model       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_row_col_stream_mux;
   logic clk = 1'b0;
   logic rst4, rst3;
   int   n_checks = 0;
   int   n_fail   = 0;

   int unsigned mat  [4][4];
   int unsigned snap [4][4];

   always #5 clk = ~clk;

   row_col_stream_mux_if #(.DATA_WIDTH(16), .MATRIX_DIM(4), .LANES(2)) bus4 ();
   row_col_stream_mux_if #(.DATA_WIDTH(16), .MATRIX_DIM(3), .LANES(3)) bus3 ();

   row_col_stream_mux #(.DATA_WIDTH(16), .MATRIX_DIM(4), .LANES(2)) u_dut4 (
      .clk   (clk),
      .reset (rst4),
      .bus   (bus4)
   );

   row_col_stream_mux #(.DATA_WIDTH(16), .MATRIX_DIM(3), .LANES(3)) u_dut3 (
      .clk   (clk),
      .reset (rst3),
      .bus   (bus3)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_matrix(input bit d3);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            if (d3) begin
               if (r < 3 && c < 3) bus3.matrix_in[(r*3+c)*16 +: 16] = mat[r][c][15:0];
            end else begin
               bus4.matrix_in[(r*4+c)*16 +: 16] = mat[r][c][15:0];
            end
         end
   endtask

   task automatic drive_req(input bit d3, input bit v, input bit mode, input int sel);
      if (d3) begin
         bus3.req_valid = v; bus3.req_mode = mode; bus3.req_select = 2'(sel);
      end else begin
         bus4.req_valid = v; bus4.req_mode = mode; bus4.req_select = 2'(sel);
      end
   endtask

   task automatic drive_ready(input bit d3, input bit rdy);
      if (d3) bus3.out_ready = rdy;
      else    bus4.out_ready = rdy;
   endtask

   task automatic rd(input bit d3, output bit v, output bit rr, output bit last,
                     output bit err, output logic [63:0] data, output int beat);
      if (d3) begin
         v = bus3.out_valid; rr = bus3.req_ready; last = bus3.out_last; err = bus3.out_err;
         data = 64'(bus3.out_data); beat = int'(bus3.out_beat);
      end else begin
         v = bus4.out_valid; rr = bus4.req_ready; last = bus4.out_last; err = bus4.out_err;
         data = 64'(bus4.out_data); beat = int'(bus4.out_beat);
      end
   endtask

   // Beat b of the requested vector, taken from the snapshot at acceptance.
   function automatic logic [63:0] model_beat(input bit mode, input int sel, input int b,
                                               input int dim, input int lanes);
      logic [63:0] res = '0;
      int unsigned e;
      for (int k = 0; k < lanes; k++) begin
         int j = b*lanes + k;
         if (sel >= dim) e = 0;
         else            e = mode ? snap[j][sel] : snap[sel][j];
         res |= 64'(e & 32'hFFFF) << (16*k);
      end
      return res;
   endfunction

   // hold < 0: random out_ready and stray requests; hold >= 0: ready low for hold cycles.
   task automatic run_req(input bit d3, input bit mode, input int sel, input int hold, input bit pattern);
      int dim   = d3 ? 3 : 4;
      int lanes = d3 ? 3 : 2;
      int beats = dim / lanes;
      int b, cyc, beat;
      bit v, rr, last, err, rdy;
      logic [63:0] data;

      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            mat[r][c] = pattern ? (r*16 + c) : $urandom_range(0, 16'hFFFF);
      set_matrix(d3);

      @(negedge clk);
      rd(d3, v, rr, last, err, data, beat);
      cyc = 0;
      while (!rr && cyc < 20) begin
         @(negedge clk);
         rd(d3, v, rr, last, err, data, beat);
         cyc++;
      end
      chk("idle_req_ready", 64'(rr), 64'd1);
      chk("idle_out_valid", 64'(v), 64'd0);

      drive_req(d3, 1'b1, mode, sel);
      snap = mat;
      @(posedge clk);
      #1;
      drive_req(d3, 1'b0, 1'b0, 0);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            mat[r][c] = pattern ? 32'hFFFF : $urandom_range(0, 16'hFFFF);
      set_matrix(d3);

      b = 0;
      cyc = 0;
      while (b < beats && cyc < 200) begin
         @(negedge clk);
         rd(d3, v, rr, last, err, data, beat);
         chk("out_valid",  64'(v), 64'd1);
         chk("busy_ready", 64'(rr), 64'd0);
         chk("out_data",   data, model_beat(mode, sel, b, dim, lanes));
         chk("out_beat",   64'(beat), 64'(b));
         chk("out_last",   64'(last), 64'(b == beats-1));
         chk("out_err",    64'(err), 64'(sel >= dim));
         if (hold < 0) begin
            rdy = ($urandom_range(0, 3) != 0);
            drive_req(d3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)));
         end else begin
            rdy = (cyc >= hold);
         end
         drive_ready(d3, rdy);
         @(posedge clk);
         if (rdy) b++;
         cyc++;
      end
      if (b < beats) chk("stream_timeout", 64'(b), 64'(beats));

      @(negedge clk);
      drive_ready(d3, 1'b0);
      drive_req(d3, 1'b0, 1'b0, 0);
      rd(d3, v, rr, last, err, data, beat);
      chk("bubble_out_valid", 64'(v), 64'd0);
      chk("bubble_req_ready", 64'(rr), 64'd1);
   endtask

   initial begin
      bit v, rr, last, err;
      logic [63:0] data;
      int beat;

      rst4 = 1'b1; rst3 = 1'b1;
      bus4.matrix_in = '0; bus3.matrix_in = '0;
      drive_req(0, 1'b0, 1'b0, 0); drive_req(1, 1'b0, 1'b0, 0);
      drive_ready(0, 1'b0); drive_ready(1, 1'b0);

      #12;
      rd(0, v, rr, last, err, data, beat);
      chk("rst_req_ready", 64'(rr), 64'd0);
      chk("rst_out_valid", 64'(v), 64'd0);
      chk("rst_out_data",  data, 64'd0);
      chk("rst_out_beat",  64'(beat), 64'd0);
      chk("rst_out_last",  64'(last), 64'd0);
      chk("rst_out_err",   64'(err), 64'd0);
      rd(1, v, rr, last, err, data, beat);
      chk("rst3_out_last", 64'(last), 64'd0);
      chk("rst3_req_ready", 64'(rr), 64'd0);

      @(negedge clk);
      rst4 = 1'b0; rst3 = 1'b0;
      @(negedge clk);
      rd(0, v, rr, last, err, data, beat);
      chk("post_rst_ready", 64'(rr), 64'd1);

      run_req(0, 1'b0, 2, 0, 1'b1);
      run_req(0, 1'b1, 1, 0, 1'b1);
      run_req(0, 1'b0, 0, 3, 1'b1);
      run_req(0, 1'b1, 3, 0, 1'b1);

      // Reset in the middle of a row-2 stream, after beat 0 has gone out.
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            mat[r][c] = r*16 + c;
      set_matrix(0);
      @(negedge clk);
      drive_req(0, 1'b1, 1'b0, 2);
      @(posedge clk);
      #1;
      drive_req(0, 1'b0, 1'b0, 0);
      drive_ready(0, 1'b1);
      @(posedge clk);
      #1;
      rd(0, v, rr, last, err, data, beat);
      chk("mid_beat", 64'(beat), 64'd1);
      drive_ready(0, 1'b0);
      rst4 = 1'b1;
      #1;
      rd(0, v, rr, last, err, data, beat);
      chk("async_out_valid", 64'(v), 64'd0);
      chk("async_req_ready", 64'(rr), 64'd0);
      chk("async_out_data",  data, 64'd0);
      chk("async_out_beat",  64'(beat), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rd(0, v, rr, last, err, data, beat);
      chk("in_rst_ready", 64'(rr), 64'd0);
      rst4 = 1'b0;
      run_req(0, 1'b0, 1, 0, 1'b1);

      run_req(1, 1'b0, 3, 0, 1'b1);
      run_req(1, 1'b0, 0, 0, 1'b1);

      for (int i = 0; i < 30; i++)
         run_req(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, 1'b0);
      for (int i = 0; i < 12; i++)
         run_req(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire

// File: doc/row_col_stream_mux.md
Name: row_col_stream_mux

Overview:
- Sequential successor to the combinational row/column selector in the matrix-multiply datapath.
- Accepts a request naming a row or a column of a square DIM x DIM matrix and snapshots that vector into a register.
- Streams the vector out in beats of LANES elements over a valid/ready handshake.
- Feeds the multiply-accumulate array, which consumes partial vectors per cycle.

Parameters:
- DATA_WIDTH, 16, bits per matrix element.
- MATRIX_DIM, 4, rows = columns of the matrix.
- LANES, 2, elements per output beat. Must divide MATRIX_DIM; illegal values are an elaboration error.
- NUM_SELECT_BITS, $clog2(MATRIX_DIM), width of the select field (minimum 1).

Ports:
- clk  in  1  single clock; all state rises on posedge.
- reset  in  1  asynchronous, active-high reset.
- matrix_in  in  MATRIX_DIM*MATRIX_DIM*DATA_WIDTH  element (r,c) at [((r*MATRIX_DIM)+c)*DATA_WIDTH +: DATA_WIDTH].
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_mode  in  1  0 = row, 1 = column.
- req_select  in  NUM_SELECT_BITS  row or column index.
- out_valid  out  1  beat present.
- out_ready  in  1  consumer accepts beat.
- out_data  out  LANES*DATA_WIDTH  lane k at [k*DATA_WIDTH +: DATA_WIDTH].
- out_last  out  1  final beat of vector.
- out_beat  out  $clog2(MATRIX_DIM/LANES) (min 1)  index of current beat.
- out_err  out  1  request select was out of range.

Behaviour:
- Reset (asynchronous) forces:
  - FSM to IDLE.
  - req_ready=0 while reset is asserted; req_ready=1 on the first clk edge after release.
  - out_valid=0, out_last=0, out_beat=0, out_err=0, out_data=0, vector register=0.
- FSM states are IDLE and STREAM.
- IDLE:
  - req_ready=1, out_valid=0.
  - On req_valid&req_ready at edge N:
    - Capture the vector: row mode vec[j]=(sel,j); column mode vec[j]=(j,sel), for j=0..MATRIX_DIM-1.
    - Capture err = (req_select >= MATRIX_DIM).
    - Go to STREAM with beat=0.
- STREAM:
  - req_ready=0, out_valid=1 from cycle N+1 (one-cycle request-to-first-beat latency).
  - out_data lane k = vec[beat*LANES+k].
  - out_last = (beat == MATRIX_DIM/LANES-1).
  - out_err is held constant for all beats of the request.
- Beat transfer (out_valid&out_ready):
  - Not last beat: beat increments.
  - Last beat: return to IDLE; req_ready=1 on the following cycle (one bubble between vectors; no back-to-back accept).
- Backpressure: while out_valid&!out_ready, out_data, out_last, out_beat and out_err hold stable.
- Snapshot: matrix_in may change freely after acceptance; the streamed data reflects the accepted cycle only.
- Out-of-range select (possible only when MATRIX_DIM is not a power of two):
  - Captured vector is all zeros and out_err=1.
  - Beat count and handshake are unchanged.
- req_valid in STREAM is ignored; it is not queued.
- Reset mid-stream: outputs clear immediately (asynchronously); the partial vector is discarded; the next request restarts at beat 0.
- All outputs are registered or decoded from registers only; there is no combinational path from inputs to outputs.

Test Plan:
(DIM=4, LANES=2, DW=16, element (r,c)=0x00rc unless noted)
- Row mode, select=2, out_ready=1 -> out_valid 1 cycle after accept:
  - beat0 = 0x00210020, out_last=0;
  - beat1 = 0x00230022, out_last=1;
  - req_ready returns 1 the next cycle.
- Column mode, select=1, out_ready=1 -> beat0 = 0x00110001, beat1 = 0x00310021 with out_last=1, out_beat 0 then 1.
- Row 0 with out_ready low for 3 cycles after out_valid rises -> out_data=0x00010000 and out_beat=0 stable for all 3 cycles; the beat advances only on the cycle out_ready=1.
- Accept column 3, then overwrite matrix_in with 0xFFFF everywhere the next cycle -> stream is still 0x00130003, 0x00330023.
- Reset pulse while in STREAM after beat0 transferred:
  - out_valid drops within the reset cycle and req_ready stays 0 during reset;
  - a new row-1 request streams 0x00110010 at out_beat=0.
- DIM=3, LANES=3, select=3 -> a single beat with out_data=0, out_err=1, out_last=1. A following select=0 gives out_err=0 and out_data=0x000200010000.
